// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_pkg
// Purpose  : Shared width default, FSM state encoding and ALU op codes.
// Revision : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

  localparam int unsigned ALU_ARB_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Purpose  : Request/response channels of both requesters plus the ALU hookup.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [1:0]       req0_op;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req1_op;
  logic             req1_ready;
  logic             resp0_valid;
  logic             resp1_valid;
  logic [WIDTH-1:0] resp_data;
  logic             resp0_ready;
  logic             resp1_ready;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_ans;
  logic [7:0]       gnt_cnt0;
  logic [7:0]       gnt_cnt1;

  // Master side: the two clients together with the external ALU.
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output resp0_ready, resp1_ready, alu_ans,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data,
    input  alu_a, alu_b, alu_op, gnt_cnt0, gnt_cnt1
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  resp0_ready, resp1_ready, alu_ans,
    output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data,
    output alu_a, alu_b, alu_op, gnt_cnt0, gnt_cnt1
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_pick
// Purpose  : Combinational two-way round-robin picker; favours !last_gnt on a tie.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_pick (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last_gnt,
  output logic o_gnt,
  output logic o_any
);

  assign o_any = i_valid0 | i_valid1;
  assign o_gnt = (i_valid0 & i_valid1) ? ~i_last_gnt : i_valid1;

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin sharing of one external ALU between two requesters.
//            Define ALU_ARB_CNT_EN to enable the saturating grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_ARB_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [1:0]       r_op;
  logic             r_id;
  logic             r_last_gnt;
  logic             w_gnt;
  logic             w_any;
  logic             w_ready0;
  logic             w_ready1;
  logic             w_req_hs;
  logic             w_resp_rdy;
  logic             w_resp_hs;

  alu_rr_pick u_pick (
    .i_valid0   (bus.req0_valid),
    .i_valid1   (bus.req1_valid),
    .i_last_gnt (r_last_gnt),
    .o_gnt      (w_gnt),
    .o_any      (w_any)
  );

  assign w_resp_rdy = r_id ? bus.resp1_ready : bus.resp0_ready;
  assign w_req_hs   = w_ready0 | w_ready1;
  assign w_resp_hs  = (r_state == RESP) & w_resp_rdy;

  // The winner is always valid, so offering ready already implies a handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_ready0    = 1'b0;
    w_ready1    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!reset && w_any) begin
          w_ready0    = ~w_gnt;
          w_ready1    = w_gnt;
          w_state_nxt = EXEC;
        end
      end
      EXEC:    w_state_nxt = RESP;
      RESP:    if (w_resp_rdy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= 2'b00;
      r_id       <= 1'b0;
      r_res      <= '0;
      r_last_gnt <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_hs) begin
        r_a  <= w_gnt ? bus.req1_a  : bus.req0_a;
        r_b  <= w_gnt ? bus.req1_b  : bus.req0_b;
        r_op <= w_gnt ? bus.req1_op : bus.req0_op;
        r_id <= w_gnt;
      end
      if (r_state == EXEC) begin
        r_res <= bus.alu_ans;
      end
      if (w_resp_hs) begin
        r_last_gnt <= r_id;
      end
    end
  end

  assign bus.req0_ready  = w_ready0;
  assign bus.req1_ready  = w_ready1;
  assign bus.resp0_valid = (r_state == RESP) & ~r_id;
  assign bus.resp1_valid = (r_state == RESP) &  r_id;
  assign bus.resp_data   = r_res;
  assign bus.alu_a       = r_a;
  assign bus.alu_b       = r_b;
  assign bus.alu_op      = r_op;

`ifdef ALU_ARB_CNT_EN
  logic [7:0] r_cnt0;
  logic [7:0] r_cnt1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt0 <= 8'h00;
      r_cnt1 <= 8'h00;
    end else begin
      if (w_ready0 && (r_cnt0 != 8'hFF)) r_cnt0 <= r_cnt0 + 8'd1;
      if (w_ready1 && (r_cnt1 != 8'hFF)) r_cnt1 <= r_cnt1 + 8'd1;
    end
  end

  assign bus.gnt_cnt0 = r_cnt0;
  assign bus.gnt_cnt1 = r_cnt1;
`else
  assign bus.gnt_cnt0 = 8'h00;
  assign bus.gnt_cnt1 = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Directed self-checking bench for alu_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(4)) bus ();

  alu_arbiter #(.WIDTH(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // External ALU model
  assign bus.alu_ans = (bus.alu_op == OP_AND) ? (bus.alu_a & bus.alu_b) :
                       (bus.alu_op == OP_OR)  ? (bus.alu_a | bus.alu_b) :
                       (bus.alu_op == OP_XOR) ? (bus.alu_a ^ bus.alu_b) :
                                                (bus.alu_a + bus.alu_b);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.req0_valid = 1'b0; bus.req0_a = 4'h0; bus.req0_b = 4'h0; bus.req0_op = 2'b00;
    bus.req1_valid = 1'b0; bus.req1_a = 4'h0; bus.req1_b = 4'h0; bus.req1_op = 2'b00;
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b1;
    bus.req0_valid = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_handshake: got %b want 0000",
               {bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid});
    end
    n_cmp++;
    if ({bus.resp_data, bus.alu_a, bus.alu_b, bus.alu_op, bus.gnt_cnt0, bus.gnt_cnt1} !== 30'd0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 0",
               {bus.resp_data, bus.alu_a, bus.alu_b, bus.alu_op, bus.gnt_cnt0, bus.gnt_cnt1});
    end
    bus.req0_valid = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_op;
    bus.req0_valid = 1'b1; bus.req0_a = 4'hC; bus.req0_b = 4'hA; bus.req0_op = OP_AND;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL single_ready: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    tick();
    bus.req0_valid = 1'b0;
    n_cmp++;
    if ({bus.resp0_valid, bus.alu_a, bus.alu_b, bus.alu_op} !== {1'b0, 4'hC, 4'hA, OP_AND}) begin
      n_err++;
      $display("FAIL single_exec: got %h want %h",
               {bus.resp0_valid, bus.alu_a, bus.alu_b, bus.alu_op}, {1'b0, 4'hC, 4'hA, OP_AND});
    end
    tick();
    n_cmp++;
    if ({bus.resp0_valid, bus.resp1_valid, bus.resp_data} !== {2'b10, 4'h8}) begin
      n_err++;
      $display("FAIL single_resp: got %b want 101000",
               {bus.resp0_valid, bus.resp1_valid, bus.resp_data});
    end
    bus.resp0_ready = 1'b1;
    tick();
    bus.resp0_ready = 1'b0;
    n_cmp++;
    if ({bus.resp0_valid, bus.resp1_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL single_done: got %b want 00", {bus.resp0_valid, bus.resp1_valid});
    end
  endtask

  task automatic test_add_wrap;
    bus.req1_valid = 1'b1; bus.req1_a = 4'hF; bus.req1_b = 4'h3; bus.req1_op = OP_ADD;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL wrap_ready: got %b want 01", {bus.req0_ready, bus.req1_ready});
    end
    tick();
    bus.req1_valid = 1'b0;
    tick();
    n_cmp++;
    if ({bus.resp0_valid, bus.resp1_valid, bus.resp_data} !== {2'b01, 4'h2}) begin
      n_err++;
      $display("FAIL wrap_resp: got %b want 010010",
               {bus.resp0_valid, bus.resp1_valid, bus.resp_data});
    end
    bus.resp1_ready = 1'b1;
    tick();
    bus.resp1_ready = 1'b0;
  endtask

  task automatic test_contention;
    logic exp_id;
    pulse_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 4'h5; bus.req0_b = 4'hA; bus.req0_op = OP_OR;
    bus.req1_valid = 1'b1; bus.req1_a = 4'h5; bus.req1_b = 4'hF; bus.req1_op = OP_XOR;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL cont_first: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    tick();
    bus.req0_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({bus.resp0_valid, bus.resp_data, bus.req1_ready} !== {1'b1, 4'hF, 1'b0}) begin
      n_err++;
      $display("FAIL cont_resp0: got %b want 111110", {bus.resp0_valid, bus.resp_data, bus.req1_ready});
    end
    bus.resp0_ready = 1'b1;
    tick();
    bus.resp0_ready = 1'b0;
    n_cmp++;
    if (bus.req1_ready !== 1'b1) begin
      n_err++;
      $display("FAIL cont_second: got %b want 1", bus.req1_ready);
    end
    tick();
    bus.req1_valid = 1'b0;
    tick();
    n_cmp++;
    if ({bus.resp1_valid, bus.resp_data} !== {1'b1, 4'hA}) begin
      n_err++;
      $display("FAIL cont_resp1: got %b want 11010", {bus.resp1_valid, bus.resp_data});
    end
    bus.resp1_ready = 1'b1;
    tick();
    bus.resp1_ready = 1'b0;
    exp_id = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      #1;
      n_cmp++;
      if ({bus.req0_ready, bus.req1_ready} !== {~exp_id, exp_id}) begin
        n_err++;
        $display("FAIL alt_grant[%0d]: got %b want %b", i,
                 {bus.req0_ready, bus.req1_ready}, {~exp_id, exp_id});
      end
      tick();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      tick();
      tick();
      bus.resp0_ready = 1'b1;
      bus.resp1_ready = 1'b1;
      tick();
      bus.resp0_ready = 1'b0;
      bus.resp1_ready = 1'b0;
      exp_id = ~exp_id;
    end
  endtask

  task automatic test_backpressure;
    bus.req0_valid = 1'b1; bus.req0_a = 4'h3; bus.req0_b = 4'h6; bus.req0_op = OP_ADD;
    tick();
    bus.req1_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({bus.resp0_valid, bus.resp_data, bus.req0_ready, bus.req1_ready} !== {1'b1, 4'h9, 2'b00}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got %b want 1100100", i,
                 {bus.resp0_valid, bus.resp_data, bus.req0_ready, bus.req1_ready});
      end
      tick();
    end
    bus.resp0_ready = 1'b1;
    #1;
    n_cmp++;
    if ({bus.resp0_valid, bus.req0_ready, bus.req1_ready} !== 3'b100) begin
      n_err++;
      $display("FAIL bp_release: got %b want 100", {bus.resp0_valid, bus.req0_ready, bus.req1_ready});
    end
    tick();
    bus.resp0_ready = 1'b0;
    n_cmp++;
    if ({bus.resp0_valid, bus.req0_ready, bus.req1_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL bp_idle: got %b want 001", {bus.resp0_valid, bus.req0_ready, bus.req1_ready});
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset_in_exec;
    bus.req0_valid = 1'b1; bus.req0_a = 4'h1; bus.req0_b = 4'h2; bus.req0_op = OP_OR;
    tick();
    bus.req0_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if ({bus.resp0_valid, bus.resp1_valid} !== 2'b00) begin
        n_err++;
        $display("FAIL rst_exec_resp[%0d]: got %b want 00", i, {bus.resp0_valid, bus.resp1_valid});
      end
      tick();
    end
    bus.req0_valid = 1'b1; bus.req0_a = 4'h6; bus.req0_b = 4'h3; bus.req0_op = OP_XOR;
    bus.req1_valid = 1'b1;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL rst_exec_order: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    n_cmp++;
    if ({bus.resp0_valid, bus.resp_data} !== {1'b1, 4'h5}) begin
      n_err++;
      $display("FAIL rst_exec_after: got %b want 10101", {bus.resp0_valid, bus.resp_data});
    end
    bus.resp0_ready = 1'b1;
    tick();
    bus.resp0_ready = 1'b0;
  endtask

  task automatic test_grant_count;
    logic [7:0] exp3;
    logic [7:0] exp_full;
`ifdef ALU_ARB_CNT_EN
    exp3     = 8'd3;
    exp_full = 8'hFF;
`else
    exp3     = 8'h00;
    exp_full = 8'h00;
`endif
    pulse_reset();
    for (int i = 0; i < 300; i++) begin
      bus.req0_valid = 1'b1; bus.req0_a = 4'h7; bus.req0_b = 4'h1; bus.req0_op = OP_ADD;
      tick();
      bus.req0_valid = 1'b0;
      tick();
      tick();
      bus.resp0_ready = 1'b1;
      tick();
      bus.resp0_ready = 1'b0;
      if (i == 2) begin
        n_cmp++;
        if (bus.gnt_cnt0 !== exp3) begin
          n_err++;
          $display("FAIL cnt0_three: got %h want %h", bus.gnt_cnt0, exp3);
        end
      end
    end
    n_cmp++;
    if ({bus.gnt_cnt0, bus.gnt_cnt1} !== {exp_full, 8'h00}) begin
      n_err++;
      $display("FAIL cnt_sat: got %h want %h", {bus.gnt_cnt0, bus.gnt_cnt1}, {exp_full, 8'h00});
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_op();
    test_add_wrap();
    test_contention();
    test_backpressure();
    test_reset_in_exec();
    test_grant_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
